sprite_fetcher: RTL and testbench

- Producer side of the per-line sprite buffer interface (`sp_num`/`wdata`/`sp_write`/`sp_info`).
- Per scanline it scans all 40 OAM entries, selects the first 10 that overlap line LY, then fetches each selected sprite's tile row from VRAM.
- It writes X, attribute, tile-low and tile-high bytes into the sprite buffer slot by slot, in the bit order the buffer consumes (bit 0 = leftmost displayed pixel).
- Sits in the PPU between OAM/VRAM read ports and the sprite buffer. It is started by the mode controller after the buffer's end-of-line clear.

---
 rtl/sprite_fetcher.sv | 227 ++++++++++++++++++++++
 tb/tb_sprite_fetcher.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_fetcher.sv
// Sprite fetcher: scans OAM for the sprites on the current line, then fetches
// each selected sprite's tile row and writes it into the per-line sprite buffer.
module sprite_fetcher #(
  parameter int unsigned OAM_ENTRIES = 40,
  parameter int unsigned MAX_SPRITES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        slow_clk_en,
  input  logic        line_start,
  input  logic [7:0]  ly,
  input  logic        obj_size,
  input  logic        obj_en,
  output logic [5:0]  oam_idx,
  input  logic [31:0] oam_rdata,
  output logic [12:0] vram_addr,
  output logic        vram_bank,
  input  logic [7:0]  vram_rdata,
  output logic [3:0]  sp_num,
  output logic [7:0]  wdata,
  output logic [3:0]  sp_write,
  input  logic [2:0]  sp_info,
  output logic        busy,
  output logic        done,
  output logic [3:0]  sp_count
);

  typedef enum logic [2:0] {
    StIdle, StScan, StFx, StFattr, StFloaddr, StFlo, StFhi, StDone
  } state_e;

  localparam logic [5:0] LastScan = 6'(OAM_ENTRIES);
  localparam logic [5:0] LastIdx  = 6'(OAM_ENTRIES - 1);
  localparam logic [3:0] MaxSlots = 4'(MAX_SPRITES);

  state_e      state_q, state_d;
  logic [5:0]  scan_q, scan_d;
  logic [5:0]  oam_idx_q, oam_idx_d;
  logic [7:0]  ly_q, ly_d;
  logic        size_q, size_d;
  logic        en_q, en_d;
  logic [3:0]  count_q, count_d;
  logic [3:0]  sp_num_q, sp_num_d;
  logic [12:0] vaddr_q, vaddr_d;
  logic        vbank_q, vbank_d;

  // Per-slot copy of the selected OAM entry: row within sprite, tile, x, attr.
  logic [3:0]  row_q  [MAX_SPRITES];
  logic [3:0]  row_d  [MAX_SPRITES];
  logic [7:0]  tile_q [MAX_SPRITES];
  logic [7:0]  tile_d [MAX_SPRITES];
  logic [7:0]  x_q    [MAX_SPRITES];
  logic [7:0]  x_d    [MAX_SPRITES];
  logic [7:0]  attr_q [MAX_SPRITES];
  logic [7:0]  attr_d [MAX_SPRITES];

  logic [7:0]  height;
  logic [7:0]  scan_row;
  logic [3:0]  cur_row;
  logic [3:0]  r;
  logic [7:0]  tile_sel;
  logic [12:0] line_addr;
  logic [7:0]  vram_rev;
  logic [7:0]  fetch_byte;

  // Address and pixel-order helpers for the slot being fetched.
  always_comb begin
    height   = size_q ? 8'd16 : 8'd8;
    scan_row = ly_q + 8'd16 - oam_rdata[7:0];
    cur_row  = row_q[sp_num_q];
    // sp_info = {vflip, hflip, bank}
    r        = sp_info[2] ? ((size_q ? 4'd15 : 4'd7) - cur_row) : cur_row;
    tile_sel = size_q ? {tile_q[sp_num_q][7:1], r[3]} : tile_q[sp_num_q];
    line_addr = {1'b0, tile_sel, r[2:0], 1'b0};
    for (int i = 0; i < 8; i++) vram_rev[i] = vram_rdata[7-i];
    // Buffer wants bit 0 = leftmost pixel; tile bit 7 is leftmost unless flipped.
    fetch_byte = sp_info[1] ? vram_rdata : vram_rev;
  end

  // Next-state: scan selection, slot capture and fetch sequencing.
  always_comb begin
    state_d   = state_q;
    scan_d    = scan_q;
    oam_idx_d = oam_idx_q;
    ly_d      = ly_q;
    size_d    = size_q;
    en_d      = en_q;
    count_d   = count_q;
    sp_num_d  = sp_num_q;
    vaddr_d   = vaddr_q;
    vbank_d   = vbank_q;
    row_d     = row_q;
    tile_d    = tile_q;
    x_d       = x_q;
    attr_d    = attr_q;
    if (slow_clk_en) begin
      if (line_start) begin
        // Also aborts any line in progress.
        ly_d      = ly;
        size_d    = obj_size;
        en_d      = obj_en;
        count_d   = 4'd0;
        oam_idx_d = 6'd0;
        scan_d    = 6'd0;
        state_d   = StScan;
      end else begin
        unique case (state_q)
          StIdle: ;
          StScan: begin
            // oam_rdata holds entry scan_q-1 on every tick but the first.
            if (scan_q != 6'd0 && scan_row < height && count_q < MaxSlots) begin
              row_d[count_q]  = scan_row[3:0];
              tile_d[count_q] = oam_rdata[23:16];
              x_d[count_q]    = oam_rdata[15:8];
              attr_d[count_q] = oam_rdata[31:24];
              count_d         = count_q + 4'd1;
            end
            if (scan_q == LastScan) begin
              if (!en_q || count_d == 4'd0) begin
                state_d = StDone;
              end else begin
                sp_num_d = 4'd0;
                state_d  = StFx;
              end
            end else begin
              scan_d = scan_q + 6'd1;
              if (scan_q < LastIdx) oam_idx_d = scan_q + 6'd1;
            end
          end
          StFx:    state_d = StFattr;
          StFattr: state_d = StFloaddr;
          StFloaddr: begin
            vaddr_d = {line_addr[12:1], 1'b1};
            vbank_d = sp_info[0];
            state_d = StFlo;
          end
          StFlo:   state_d = StFhi;
          StFhi: begin
            if (sp_num_q == count_q - 4'd1) begin
              state_d = StDone;
            end else begin
              sp_num_d = sp_num_q + 4'd1;
              state_d  = StFx;
            end
          end
          StDone:  state_d = StIdle;
          default: state_d = StIdle;
        endcase
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      scan_q    <= '0;
      oam_idx_q <= '0;
      ly_q      <= '0;
      size_q    <= 1'b0;
      en_q      <= 1'b0;
      count_q   <= '0;
      sp_num_q  <= '0;
      vaddr_q   <= '0;
      vbank_q   <= 1'b0;
      row_q     <= '{default: '0};
      tile_q    <= '{default: '0};
      x_q       <= '{default: '0};
      attr_q    <= '{default: '0};
    end else begin
      state_q   <= state_d;
      scan_q    <= scan_d;
      oam_idx_q <= oam_idx_d;
      ly_q      <= ly_d;
      size_q    <= size_d;
      en_q      <= en_d;
      count_q   <= count_d;
      sp_num_q  <= sp_num_d;
      vaddr_q   <= vaddr_d;
      vbank_q   <= vbank_d;
      row_q     <= row_d;
      tile_q    <= tile_d;
      x_q       <= x_d;
      attr_q    <= attr_d;
    end
  end

  // Buffer write strobes/data and VRAM address presentation.
  always_comb begin
    sp_write  = 4'b0000;
    wdata     = 8'h00;
    vram_addr = vaddr_q;
    vram_bank = vbank_q;
    unique case (state_q)
      StFx: begin
        wdata    = x_q[sp_num_q];
        sp_write = 4'b0001;
      end
      StFattr: begin
        wdata    = attr_q[sp_num_q];
        sp_write = 4'b0010;
      end
      StFloaddr: begin
        // Address must be on the bus this tick so the byte arrives for F_LO.
        vram_addr = line_addr;
        vram_bank = sp_info[0];
      end
      StFlo: begin
        wdata    = fetch_byte;
        sp_write = 4'b0100;
      end
      StFhi: begin
        wdata    = fetch_byte;
        sp_write = 4'b1000;
      end
      default: ;
    endcase
    if (!slow_clk_en || line_start) sp_write = 4'b0000;
  end

  assign oam_idx  = oam_idx_q;
  assign sp_num   = sp_num_q;
  assign sp_count = count_q;
  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone);

endmodule

// File: tb/tb_sprite_fetcher.sv
// Bench for sprite_fetcher: OAM/VRAM/sprite-buffer environment, a per-line
// model of the expected write schedule, and a per-cycle compare process.
module tb_sprite_fetcher;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        slow_clk_en = 1'b1;
  logic        line_start = 1'b0;
  logic [7:0]  ly = '0;
  logic        obj_size = 1'b0;
  logic        obj_en = 1'b0;
  logic [5:0]  oam_idx;
  logic [31:0] oam_rdata = '0;
  logic [12:0] vram_addr;
  logic        vram_bank;
  logic [7:0]  vram_rdata = '0;
  logic [3:0]  sp_num;
  logic [7:0]  wdata;
  logic [3:0]  sp_write;
  logic [2:0]  sp_info;
  logic        busy;
  logic        done;
  logic [3:0]  sp_count;

  sprite_fetcher #(.OAM_ENTRIES(40), .MAX_SPRITES(10)) dut (
    .clk(clk), .reset(reset), .slow_clk_en(slow_clk_en), .line_start(line_start),
    .ly(ly), .obj_size(obj_size), .obj_en(obj_en), .oam_idx(oam_idx),
    .oam_rdata(oam_rdata), .vram_addr(vram_addr), .vram_bank(vram_bank),
    .vram_rdata(vram_rdata), .sp_num(sp_num), .wdata(wdata), .sp_write(sp_write),
    .sp_info(sp_info), .busy(busy), .done(done), .sp_count(sp_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] o;
    for (int i = 0; i < 8; i++) o[i] = b[7-i];
    return o;
  endfunction

  // Environment memories: synchronous reads advancing on enabled ticks.
  logic [31:0] oam  [0:63];
  logic [7:0]  vram [0:16383];
  always @(posedge clk) begin
    if (slow_clk_en) begin
      oam_rdata  <= oam[oam_idx];
      vram_rdata <= vram[{vram_bank, vram_addr}];
    end
  end

  // Sprite buffer model; sp_info = {vflip, hflip, bank} of the addressed slot.
  logic [7:0] buf_x [0:15];
  logic [7:0] buf_attr [0:15];
  logic [7:0] buf_lo [0:15];
  logic [7:0] buf_hi [0:15];
  assign sp_info = {buf_attr[sp_num][6], buf_attr[sp_num][5], buf_attr[sp_num][3]};

  // Line model: expected slot contents and schedule.
  int         exp_n = 0;
  int         done_tick = 0;
  bit         model_en = 1'b0;
  logic [7:0] exp_x [0:9];
  logic [7:0] exp_attr [0:9];
  logic [7:0] exp_lo [0:9];
  logic [7:0] exp_hi [0:9];
  logic [12:0] exp_addr [0:9];
  logic       exp_bank [0:9];

  // Tick bookkeeping (tick 0 = line_start tick) plus buffer writes.
  int tick = 0;
  bit active = 1'b0;
  int done_at = 0;
  int wr_cnt = 0;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      active  <= 1'b0;
      tick    <= 0;
      done_at <= 0;
      wr_cnt  <= 0;
    end else if (slow_clk_en) begin
      if (line_start) begin
        active  <= 1'b1;
        tick    <= 0;
        done_at <= 0;
        wr_cnt  <= 0;
        for (int i = 0; i < 16; i++) begin
          buf_x[i] <= '0; buf_attr[i] <= '0; buf_lo[i] <= '0; buf_hi[i] <= '0;
        end
      end else begin
        if (active) begin
          tick <= tick + 1;
          if (tick + 1 == done_tick) active <= 1'b0;
        end
        if (done) done_at <= tick + 1;
        if (sp_write != 4'b0000) wr_cnt <= wr_cnt + 1;
        if (sp_write[0]) buf_x[sp_num] <= wdata;
        if (sp_write[1]) buf_attr[sp_num] <= wdata;
        if (sp_write[2]) buf_lo[sp_num] <= wdata;
        if (sp_write[3]) buf_hi[sp_num] <= wdata;
      end
    end
  end

  // Per-cycle compare against the model for the upcoming enabled tick.
  always @(negedge clk) begin : mon
    int up;
    int b;
    logic [3:0] we_e;
    logic [7:0] wd_e;
    logic [3:0] slot_e;
    if (reset && !line_start) begin
      up = tick + 1;
      we_e = '0; wd_e = '0; slot_e = '0;
      if (active && up <= 40) check("oam_idx", 32'(oam_idx), 32'(up - 1));
      if (active && model_en) begin
        for (int i = 0; i < exp_n; i++) begin
          b = 42 + 5 * i;
          if (up == b)     begin we_e = 4'b0001; wd_e = exp_x[i];    slot_e = 4'(i); end
          if (up == b + 1) begin we_e = 4'b0010; wd_e = exp_attr[i]; slot_e = 4'(i); end
          if (up == b + 3) begin we_e = 4'b0100; wd_e = exp_lo[i];   slot_e = 4'(i); end
          if (up == b + 4) begin we_e = 4'b1000; wd_e = exp_hi[i];   slot_e = 4'(i); end
          if (up == b + 2) begin
            check("vram_addr_lo", 32'(vram_addr), 32'(exp_addr[i]));
            check("vram_bank_lo", 32'(vram_bank), 32'(exp_bank[i]));
          end
          if (up == b + 3 || up == b + 4) begin
            check("vram_addr_hi", 32'(vram_addr), 32'(exp_addr[i] | 13'd1));
            check("vram_bank_hi", 32'(vram_bank), 32'(exp_bank[i]));
          end
        end
      end
      if (!slow_clk_en) we_e = '0;
      check("busy", 32'(busy), 32'(active));
      check("done", 32'(done), 32'(active && up == done_tick));
      check("sp_write", 32'(sp_write), 32'(we_e));
      if (we_e != 4'b0000) begin
        check("sp_num", 32'(sp_num), 32'(slot_e));
        check("wdata", 32'(wdata), 32'(wd_e));
      end
      if (active && up > 41) check("sp_count", 32'(sp_count), 32'(exp_n));
    end else if (reset) begin
      check("sp_write_at_line_start", 32'(sp_write), 32'd0);
    end
  end

  // Dot-rate enable, high about three ticks in four.
  initial begin
    forever begin
      @(posedge clk);
      #1 slow_clk_en = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic wait_ticks(input int n);
    int c = 0;
    while (c < n) begin
      @(posedge clk);
      if (slow_clk_en) c++;
    end
    #1;
  endtask

  task automatic wait_idle();
    int g = 0;
    while (active && g < 3000) begin
      @(posedge clk);
      g++;
    end
    #1;
    check("busy_after_line", 32'(busy), 32'd0);
  endtask

  // Build the expected line from OAM/VRAM contents, then pulse line_start.
  task automatic start_line(input logic [7:0] l, input logic s, input logic e);
    logic [7:0] h, row, a, tl, t, lo, hi;
    logic [3:0] r4;
    logic [12:0] ad;
    exp_n = 0;
    h = s ? 8'd16 : 8'd8;
    for (int k = 0; k < 40; k++) begin
      row = l + 8'd16 - oam[k][7:0];
      if (row < h && exp_n < 10) begin
        a  = oam[k][31:24];
        tl = oam[k][23:16];
        r4 = a[6] ? 4'(h - 8'd1 - row) : row[3:0];
        t  = s ? {tl[7:1], r4[3]} : tl;
        ad = {1'b0, t, r4[2:0], 1'b0};
        lo = vram[{a[3], ad}];
        hi = vram[{a[3], ad | 13'd1}];
        exp_x[exp_n]    = oam[k][15:8];
        exp_attr[exp_n] = a;
        exp_addr[exp_n] = ad;
        exp_bank[exp_n] = a[3];
        exp_lo[exp_n]   = a[5] ? lo : rev8(lo);
        exp_hi[exp_n]   = a[5] ? hi : rev8(hi);
        exp_n++;
      end
    end
    model_en  = e;
    done_tick = (e && exp_n > 0) ? 42 + 5 * exp_n : 42;
    ly = l; obj_size = s; obj_en = e;
    line_start = 1'b1;
    do @(posedge clk); while (!slow_clk_en);
    #1 line_start = 1'b0;
  endtask

  task automatic clear_oam();
    for (int k = 0; k < 64; k++) oam[k] = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic [7:0] l, y;
    logic s;
    clear_oam();
    for (int k = 0; k < 16384; k++) vram[k] = 8'($urandom);
    #1 reset = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sp_count", 32'(sp_count), 32'd0);
    check("rst_sp_write", 32'(sp_write), 32'd0);
    check("rst_oam_idx", 32'(oam_idx), 32'd0);
    #20 reset = 1'b1;
    wait_ticks(2);

    // One 8x8 sprite, row 3 of tile 0x12.
    oam[5] = {8'h00, 8'h12, 8'd20, 8'd16};
    vram[14'h0126] = 8'hC5;
    vram[14'h0127] = 8'h0F;
    start_line(8'd3, 1'b0, 1'b1);
    wait_idle();
    check("t1_count", 32'(sp_count), 32'd1);
    check("t1_x", 32'(buf_x[0]), 32'd20);
    check("t1_attr", 32'(buf_attr[0]), 32'h00);
    check("t1_lo", 32'(buf_lo[0]), 32'hA3);
    check("t1_hi", 32'(buf_hi[0]), 32'hF0);
    check("t1_done_tick", 32'(done_at), 32'd47);
    check("t1_writes", 32'(wr_cnt), 32'd4);

    // hflip keeps raw order; no hflip reverses.
    oam[5] = {8'h20, 8'h12, 8'd20, 8'd16};
    vram[14'h0126] = 8'h80;
    start_line(8'd3, 1'b0, 1'b1);
    wait_idle();
    check("hflip_lo", 32'(buf_lo[0]), 32'h80);
    oam[5] = {8'h00, 8'h12, 8'd20, 8'd16};
    start_line(8'd3, 1'b0, 1'b1);
    wait_idle();
    check("noflip_lo", 32'(buf_lo[0]), 32'h01);

    // Bank 1 tile data.
    oam[5] = {8'h08, 8'h12, 8'd20, 8'd16};
    vram[14'h2126] = 8'h01;
    start_line(8'd3, 1'b0, 1'b1);
    wait_idle();
    check("bank1_lo", 32'(buf_lo[0]), 32'h80);

    // Sprites disabled: scan only.
    start_line(8'd3, 1'b0, 1'b0);
    wait_idle();
    check("objoff_done_tick", 32'(done_at), 32'd42);
    check("objoff_writes", 32'(wr_cnt), 32'd0);
    check("objoff_count", 32'(sp_count), 32'd1);

    // 8x16 vflip: row 2 -> r 13, address 0x13A/0x13B.
    clear_oam();
    oam[0] = {8'h40, 8'h13, 8'd50, 8'd16};
    vram[14'h013A] = 8'h12;
    vram[14'h013B] = 8'h01;
    start_line(8'd2, 1'b1, 1'b1);
    wait_idle();
    check("vflip_lo", 32'(buf_lo[0]), 32'h48);
    check("vflip_hi", 32'(buf_hi[0]), 32'h80);

    // All 40 overlap: first 10 taken.
    for (int k = 0; k < 40; k++) oam[k] = {8'(k), 8'(k + 3), 8'(k * 5 + 1), 8'd16};
    start_line(8'd0, 1'b0, 1'b1);
    wait_idle();
    check("full_count", 32'(sp_count), 32'd10);
    check("full_writes", 32'(wr_cnt), 32'd40);
    check("full_x0", 32'(buf_x[0]), 32'd1);
    check("full_x9", 32'(buf_x[9]), 32'd46);
    check("full_done_tick", 32'(done_at), 32'd92);

    // Abort mid-fetch with a new line that selects nothing.
    start_line(8'd0, 1'b0, 1'b1);
    wait_ticks(60);
    clear_oam();
    start_line(8'd0, 1'b0, 1'b1);
    check("abort_count", 32'(sp_count), 32'd0);
    check("abort_busy", 32'(busy), 32'd1);
    wait_idle();
    check("abort_done_tick", 32'(done_at), 32'd42);
    check("abort_writes", 32'(wr_cnt), 32'd0);

    // Asynchronous reset mid-scan.
    for (int k = 0; k < 40; k++) oam[k] = {8'(k), 8'(k + 3), 8'(k * 5 + 1), 8'd16};
    start_line(8'd0, 1'b0, 1'b1);
    wait_ticks(10);
    #1 reset = 1'b0;
    #1;
    check("areset_oam_idx", 32'(oam_idx), 32'd0);
    check("areset_vram_addr", 32'(vram_addr), 32'd0);
    check("areset_vram_bank", 32'(vram_bank), 32'd0);
    check("areset_sp_num", 32'(sp_num), 32'd0);
    check("areset_wdata", 32'(wdata), 32'd0);
    check("areset_sp_write", 32'(sp_write), 32'd0);
    check("areset_busy", 32'(busy), 32'd0);
    check("areset_done", 32'(done), 32'd0);
    check("areset_sp_count", 32'(sp_count), 32'd0);
    @(negedge clk);
    #2 reset = 1'b1;
    wait_ticks(2);

    // Randomized lines, some aborted partway.
    for (int it = 0; it < 24; it++) begin
      l = 8'($urandom_range(0, 143));
      s = 1'($urandom_range(0, 1));
      for (int k = 0; k < 40; k++) begin
        y = l + 8'd16 - 8'($urandom_range(0, s ? 40 : 24));
        oam[k] = {8'($urandom), 8'($urandom), 8'($urandom), y};
      end
      start_line(l, s, $urandom_range(0, 7) != 0);
      if ($urandom_range(0, 3) == 0) begin
        w = $urandom_range(1, done_tick - 2);
        wait_ticks(w);
      end else begin
        wait_idle();
      end
    end
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
